// File: rtl/store_data_aligner_if.sv
// Request/memory-write bundle for store_data_aligner.
// The master side issues store requests and accepts memory writes; the slave side is the aligner.
interface store_data_aligner_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_be;

  modport master (
    output in_valid, in_addr, in_data, in_size, out_ready,
    input  in_ready, out_valid, out_addr, out_data, out_be
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_size, out_ready,
    output in_ready, out_valid, out_addr, out_data, out_be
  );
endinterface

// File: rtl/store_data_aligner.sv
// Big-endian SB/SH/SW lane formatter feeding data memory through a 2-entry FIFO.
// Define MISALIGN_TRAP_EN to drop misaligned/reserved-size stores and pulse err instead.
module store_data_aligner (
  input  logic                       clk,
  input  logic                       rst,
  store_data_aligner_if.slave        bus,
  output logic                       err,
  output logic [31:0]                err_addr,
  output logic [15:0]                store_count
);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  entry_t      fifo_q [2];
  entry_t      head;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  occ;
  logic [1:0]  occ_next;
  logic        in_ready_q;
  logic [1:0]  off;
  logic [31:0] fmt_data;
  logic [3:0]  fmt_be;
  logic        in_fire;
  logic        enq;
  logic        pop;

  assign off     = bus.in_addr[1:0];
  assign in_fire = bus.in_valid & in_ready_q;
  assign pop     = bus.out_valid & bus.out_ready;

  // Replicate the source lane across the word so memory only needs the byte enables.
  always_comb begin
    fmt_data = bus.in_data;
    fmt_be   = 4'b1111;
    case (bus.in_size)
      2'b00: begin
        fmt_data = {4{bus.in_data[7:0]}};
        fmt_be   = 4'b1000 >> off;
      end
      2'b01: begin
        fmt_data = {2{bus.in_data[15:0]}};
        fmt_be   = off[1] ? 4'b0011 : 4'b1100;
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (bus.in_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  assign enq = in_fire & ~misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      err <= in_fire & misaligned;
      if (in_fire & misaligned) begin
        err_addr <= bus.in_addr;
      end
    end
  end
`else
  assign enq      = in_fire;
  assign err      = 1'b0;
  assign err_addr = '0;
`endif

  always_comb begin
    occ_next = occ;
    case ({enq, pop})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  // in_ready is registered from next occupancy, so a full FIFO never sees push and pop together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
      in_ready_q  <= 1'b1;
      store_count <= 16'd0;
    end else begin
      if (enq) begin
        fifo_q[wr_ptr] <= '{addr: {bus.in_addr[31:2], 2'b00}, data: fmt_data, be: fmt_be};
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr      <= ~rd_ptr;
        store_count <= store_count + 16'd1;
      end
      occ        <= occ_next;
      in_ready_q <= (occ_next != 2'd2);
    end
  end

  assign head          = fifo_q[rd_ptr];
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_addr  = head.addr;
  assign bus.out_data  = head.data;
  assign bus.out_be    = head.be;

endmodule

// File: tb/tb_store_data_aligner.sv
// Directed self-checking bench for store_data_aligner; honours MISALIGN_TRAP_EN if defined.
module tb_store_data_aligner;

  logic        clk;
  logic        rst;
  logic        err;
  logic [31:0] err_addr;
  logic [15:0] store_count;
  int          total;
  int          bad;
  logic [15:0] exp_count;

  store_data_aligner_if bus ();

  store_data_aligner dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err         (err),
    .err_addr    (err_addr),
    .store_count (store_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [31:0] addr,
                                input logic [31:0] data, input logic [1:0] size);
    bus.in_valid = valid;
    bus.in_addr  = addr;
    bus.in_data  = data;
    bus.in_size  = size;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_count = 16'd0;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    apply_stimulus(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    tick();

    // Reset values
    check_output("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_output("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_output("rst_out_addr", bus.out_addr, 32'd0);
    check_output("rst_out_data", bus.out_data, 32'd0);
    check_output("rst_out_be", {28'd0, bus.out_be}, 32'd0);
    check_output("rst_err", {31'd0, err}, 32'd0);
    check_output("rst_err_addr", err_addr, 32'd0);
    check_output("rst_count", {16'd0, store_count}, 32'd0);
    rst = 1'b0;
    tick();

    // SB at offset 3
    apply_stimulus(1'b1, 32'h0000_1003, 32'h0000_00A5, 2'b00);
    tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 2'b00);
    check_output("sb3_valid", {31'd0, bus.out_valid}, 32'd1);
    check_output("sb3_addr", bus.out_addr, 32'h0000_1000);
    check_output("sb3_data", bus.out_data, 32'hA5A5_A5A5);
    check_output("sb3_be", {28'd0, bus.out_be}, 32'b0001);
    check_output("sb3_err", {31'd0, err}, 32'd0);
    bus.out_ready = 1'b1;
    tick();
    exp_count++;
    check_output("sb3_count", {16'd0, store_count}, {16'd0, exp_count});
    check_output("sb3_drained", {31'd0, bus.out_valid}, 32'd0);

    // SB at offset 1, then SH, then SW streamed with out_ready high
    apply_stimulus(1'b1, 32'h0000_1001, 32'h1234_5677, 2'b00);
    tick();
    check_output("sb1_data", bus.out_data, 32'h7777_7777);
    check_output("sb1_be", {28'd0, bus.out_be}, 32'b0100);
    apply_stimulus(1'b1, 32'h0000_2002, 32'h1234_BEEF, 2'b01);
    tick();
    exp_count++;
    check_output("sh_addr", bus.out_addr, 32'h0000_2000);
    check_output("sh_data", bus.out_data, 32'hBEEF_BEEF);
    check_output("sh_be", {28'd0, bus.out_be}, 32'b0011);
    apply_stimulus(1'b1, 32'h0000_2004, 32'hDEAD_1234, 2'b10);
    tick();
    exp_count++;
    apply_stimulus(1'b0, 32'h0, 32'h0, 2'b00);
    check_output("sw_addr", bus.out_addr, 32'h0000_2004);
    check_output("sw_data", bus.out_data, 32'hDEAD_1234);
    check_output("sw_be", {28'd0, bus.out_be}, 32'b1111);
    tick();
    exp_count++;
    check_output("stream_count", {16'd0, store_count}, {16'd0, exp_count});
    check_output("stream_empty", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure: two words absorbed, third held off until a slot frees
    bus.out_ready = 1'b0;
    apply_stimulus(1'b1, 32'h0000_4000, 32'h1111_0001, 2'b10);
    tick();
    check_output("bp_ready1", {31'd0, bus.in_ready}, 32'd1);
    apply_stimulus(1'b1, 32'h0000_4004, 32'h2222_0002, 2'b10);
    tick();
    check_output("bp_ready2", {31'd0, bus.in_ready}, 32'd0);
    apply_stimulus(1'b1, 32'h0000_4008, 32'h3333_0003, 2'b10);
    tick();
    check_output("bp_full_ready", {31'd0, bus.in_ready}, 32'd0);
    check_output("bp_stable_data", bus.out_data, 32'h1111_0001);
    check_output("bp_stable_addr", bus.out_addr, 32'h0000_4000);
    bus.out_ready = 1'b1;
    tick();
    exp_count++;
    check_output("bp_head2", bus.out_data, 32'h2222_0002);
    check_output("bp_count1", {16'd0, store_count}, {16'd0, exp_count});
    check_output("bp_ready_back", {31'd0, bus.in_ready}, 32'd1);
    tick();
    exp_count++;
    apply_stimulus(1'b0, 32'h0, 32'h0, 2'b00);
    check_output("bp_head3", bus.out_data, 32'h3333_0003);
    check_output("bp_addr3", bus.out_addr, 32'h0000_4008);
    check_output("bp_count2", {16'd0, store_count}, {16'd0, exp_count});
    tick();
    exp_count++;
    check_output("bp_count3", {16'd0, store_count}, {16'd0, exp_count});
    check_output("bp_empty", {31'd0, bus.out_valid}, 32'd0);

    // Misaligned half and reserved size
    bus.out_ready = 1'b0;
    apply_stimulus(1'b1, 32'h0000_3001, 32'h0000_ABCD, 2'b01);
    tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 2'b00);
`ifdef MISALIGN_TRAP_EN
    check_output("mis_err", {31'd0, err}, 32'd1);
    check_output("mis_err_addr", err_addr, 32'h0000_3001);
    check_output("mis_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check_output("mis_err_pulse", {31'd0, err}, 32'd0);
`else
    check_output("mis_err", {31'd0, err}, 32'd0);
    check_output("mis_valid", {31'd0, bus.out_valid}, 32'd1);
    check_output("mis_be", {28'd0, bus.out_be}, 32'b1100);
    check_output("mis_data", bus.out_data, 32'hABCD_ABCD);
    bus.out_ready = 1'b1;
    tick();
    exp_count++;
    bus.out_ready = 1'b0;
`endif
    apply_stimulus(1'b1, 32'h0000_5002, 32'hCAFE_F00D, 2'b11);
    tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 2'b00);
`ifdef MISALIGN_TRAP_EN
    check_output("rsv_err", {31'd0, err}, 32'd1);
    check_output("rsv_err_addr", err_addr, 32'h0000_5002);
    check_output("rsv_valid", {31'd0, bus.out_valid}, 32'd0);
`else
    check_output("rsv_err", {31'd0, err}, 32'd0);
    check_output("rsv_addr", bus.out_addr, 32'h0000_5000);
    check_output("rsv_data", bus.out_data, 32'hCAFE_F00D);
    check_output("rsv_be", {28'd0, bus.out_be}, 32'b1111);
    bus.out_ready = 1'b1;
    tick();
    exp_count++;
    bus.out_ready = 1'b0;
`endif
    check_output("mis_count", {16'd0, store_count}, {16'd0, exp_count});

    // Asynchronous reset with two entries queued
    apply_stimulus(1'b1, 32'h0000_6000, 32'h6666_0000, 2'b10);
    tick();
    apply_stimulus(1'b1, 32'h0000_6004, 32'h6666_0004, 2'b10);
    tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 2'b00);
    check_output("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    check_output("pre_rst_ready", {31'd0, bus.in_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_output("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    check_output("arst_ready", {31'd0, bus.in_ready}, 32'd1);
    check_output("arst_data", bus.out_data, 32'd0);
    check_output("arst_count", {16'd0, store_count}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_output("post_rst_count", {16'd0, store_count}, 32'd0);
    check_output("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);

    // 65536 back-to-back word transfers wrap the counter
    bus.out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      apply_stimulus(1'b1, 32'h0001_0000 + (i << 2), i, 2'b10);
      tick();
    end
    apply_stimulus(1'b0, 32'h0, 32'h0, 2'b00);
    check_output("wrap_ready", {31'd0, bus.in_ready}, 32'd1);
    check_output("wrap_ffff", {16'd0, store_count}, 32'h0000_FFFF);
    check_output("wrap_last_data", bus.out_data, 32'd65535);
    tick();
    check_output("wrap_zero", {16'd0, store_count}, 32'd0);
    check_output("wrap_empty", {31'd0, bus.out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Backstop so the bench always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/store_data_aligner.md
# store_data_aligner

Store-path byte-lane formatter for the MIPS memory stage, the write-direction counterpart of the load sign-extension path. Accepts SB/SH/SW requests carrying a byte address and a 32-bit register value. Emits word-aligned address, lane-replicated write data and byte enables to data memory through a 2-entry buffered valid/ready interface. Byte order is big-endian (MIPS): byte offset 0 occupies data[31:24].

## Interface
Parameters:
- none; all widths are fixed at 32-bit data and address.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  store request present.
- in_ready  out  1  buffer can accept a request.
- in_addr  in  32  byte address.
- in_data  in  32  source register value (rt).
- in_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- out_valid  out  1  memory write pending.
- out_ready  in  1  memory accepts the write.
- out_addr  out  32  word address, {in_addr[31:2], 2'b00}.
- out_data  out  32  lane-formatted write data.
- out_be  out  4  byte enables; be[3] = data[31:24].
- err  out  1  one-cycle misaligned/reserved-size pulse.
- err_addr  out  32  address of the last errored request.
- store_count  out  16  writes completed on the output side; wraps at 0xFFFF→0.

## Operation
- Handshake fires when in_valid & in_ready. Output transfer fires when out_valid & out_ready.
- Let off = in_addr[1:0].
- Byte request:
  - out_data = {4{in_data[7:0]}}.
  - out_be: off 0 → 1000, off 1 → 0100, off 2 → 0010, off 3 → 0001.
- Half request:
  - out_data = {2{in_data[15:0]}}.
  - out_be: off[1] = 0 → 1100, off[1] = 1 → 0011.
- Word request: out_data = in_data, out_be = 1111.
- The formatted entry {out_addr, out_data, out_be} is written into a 2-entry FIFO. Outputs are driven from the head entry.
- in_ready = (occupancy != 2). out_valid = (occupancy != 0).
- Simultaneous push and pop keeps occupancy unchanged. Entry order is preserved.
- store_count increments by 1 on each output transfer.
- Misaligned conditions: half with off[0] = 1; word with off != 0; size 11 always. Handling depends on Configuration.
- Reset mid-operation: FIFO contents are discarded immediately, with no completion of pending writes.

## Timing
- Latency: a request accepted at edge N appears on out_* after edge N (visible in cycle N+1) when the FIFO was empty.
- Throughput: 1 request per cycle while out_ready is held high.
- With out_ready low, 2 requests are absorbed. in_ready drops in the cycle after the 2nd accept.
- in_ready is a registered function of occupancy. It does not depend combinationally on out_ready, so a pop and a push cannot both occur when full.
- out_data, out_addr and out_be stay stable while out_valid = 1 and out_ready = 0.
- err asserts for exactly one cycle following the accepting edge. err_addr updates on the same edge.
- Values during and after reset:
  - in_ready = 1, out_valid = 0.
  - out_addr, out_data, out_be = 0.
  - err = 0, err_addr = 0, store_count = 0.
  - occupancy = 0.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A misaligned or size-11 request is still handshaken (in_ready consumed normally).
  - It is not enqueued and never reaches memory.
  - err pulses and err_addr = in_addr.
- MISALIGN_TRAP_EN undefined:
  - No traps; err is tied 0 and err_addr is tied 0.
  - Half uses off[1] only; word ignores off; size 11 is treated as word.
  - Every request is enqueued.

## Test plan
- SB, addr 0x1003, data 0x000000A5 → out_addr 0x1000, out_data 0xA5A5A5A5, out_be 0001, out_valid in the cycle after accept.
- SH, addr 0x2002, data 0x1234BEEF → out_data 0xBEEFBEEF, out_be 0011. SW, addr 0x2004 → out_be 1111, out_data passes through unchanged.
- Backpressure with out_ready = 0:
  - Push 3 words back-to-back → in_ready low after the 2nd accept.
  - Release out_ready → data drains in order, store_count = 2, then the 3rd word is accepted.
- SH at 0x3001:
  - With MISALIGN_TRAP_EN → err one-cycle pulse, err_addr 0x3001, out_valid stays 0.
  - Without the macro → out_be 1100, err 0.
- Assert rst with 2 entries queued → out_valid 0 and in_ready 1 immediately (asynchronous). After release, store_count is 0.
- Run 65536 word transfers → store_count wraps from 0xFFFF to 0x0000.
